// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced IDLE/RUN/PAUSE/LAP stopwatch sequencer with count-tick prescaler; define SW_LAPCNT_EN to add lap_cnt
module stopwatch_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clr,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic       disp_freeze,
  output logic       running,
`ifdef SW_LAPCNT_EN
  output logic [3:0] lap_cnt,
`endif
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  state_t state_q, state_d;
  logic [2:0] sync1_q, sync2_q, deb_q, deb_d, ev_q, ev_d;
  logic [DW-1:0] dbc_q [3];
  logic [DW-1:0] dbc_d [3];
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d, clr_q, clr_d, run_q, run_d, frz_q, frz_d;
  logic ev_start, ev_lap, ev_clr, pre_clr, counting;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = (sync2_q[i] == deb_q[i] || dbc_q[i] == DW'(DEBOUNCE_CYC - 1)) ? '0 : dbc_q[i] + 1'b1;
      deb_d[i] = (sync2_q[i] != deb_q[i] && dbc_q[i] == DW'(DEBOUNCE_CYC - 1)) ? ~deb_q[i] : deb_q[i];
    end
    ev_d = deb_d & ~deb_q;
  end
  assign ev_clr   = ev_q[2];
  assign ev_start = ev_q[0] & ~ev_q[2];
  assign ev_lap   = ev_q[1] & ~ev_q[0] & ~ev_q[2];
  assign counting = state_q == RUN || state_q == LAP;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ev_start ? RUN : IDLE;
      RUN:     state_d = ev_start ? PAUSE : ev_lap ? LAP : RUN;
      LAP:     state_d = ev_start ? PAUSE : ev_lap ? RUN : LAP;
      PAUSE:   state_d = ev_clr ? IDLE : ev_start ? RUN : PAUSE;
      default: state_d = IDLE;
    endcase
    clr_d   = ev_clr && (state_q == IDLE || state_q == PAUSE);
    pre_clr = clr_d || (state_q == IDLE && ev_start);
    tick_d  = counting && pre_q == PW'(TICK_DIV - 1);
    pre_d   = pre_clr ? '0 : !counting ? pre_q : tick_d ? '0 : pre_q + 1'b1;
    run_d   = state_d == RUN || state_d == LAP;
    frz_d   = state_d == LAP;
  end
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      ev_q    <= '0;
      dbc_q   <= '{default: '0};
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      sync1_q <= {btn_clr, btn_lap, btn_start};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      ev_q    <= ev_d;
      dbc_q   <= dbc_d;
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      run_q   <= run_d;
      frz_q   <= frz_d;
    end
  end
`ifdef SW_LAPCNT_EN
  logic [3:0] lap_q, lap_d;
  always_comb lap_d = clr_d ? 4'd0 : (state_q == RUN && state_d == LAP && lap_q != 4'd15) ? lap_q + 4'd1 : lap_q;
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) lap_q <= 4'd0;
    else lap_q <= lap_d;
  end
  assign lap_cnt = lap_q;
`endif
  assign cnt_tick    = tick_q;
  assign cnt_clr     = clr_q;
  assign disp_freeze = frz_q;
  assign running     = run_q;
  assign state       = state_q;
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run-control sequencer for the 4-digit BCD stopwatch datapath and its multiplexed 7-segment display. It debounces three push-buttons and runs an IDLE/RUN/PAUSE/LAP state machine. It divides mclk into count ticks and drives three controls: count-enable pulses, a clear pulse, and a display-freeze level. The BCD counter and display mux consume these outputs directly.

Parameters:
TICK_DIV, 100000, mclk cycles per count tick (1 ms at 100 MHz); legal range 2..2^27.
DEBOUNCE_CYC, 1000000, consecutive stable synchronized samples required to accept a button level change; legal range >= 1.

Ports:
mclk  input  1  system clock; all flops on posedge.
rst  input  1  asynchronous, active-high reset.
btn_start  input  1  raw start/stop button, async, active-high.
btn_lap  input  1  raw lap button, async, active-high.
btn_clr  input  1  raw clear button, async, active-high.
cnt_tick  output  1  one-cycle pulse; BCD counter advances one count.
cnt_clr  output  1  one-cycle pulse; BCD counter loads 0000.
disp_freeze  output  1  level; display mux holds its last captured digits while high.
running  output  1  high in RUN and LAP.
state  output  2  current state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Behaviour:
- Reset (async, immediate, any time, including mid-count or mid-debounce):
  - state=IDLE.
  - cnt_tick=0, cnt_clr=0, disp_freeze=0, running=0.
  - Prescaler=0.
  - All synchronizer and debounce flops=0.
  - Pending events are discarded.
- Button front end, per button:
  - 2-flop synchronizer, then debounce counter.
  - The counter increments while the synchronized sample differs from the debounced level and clears when they match.
  - On reaching DEBOUNCE_CYC-1 the debounced level flips and the counter clears.
  - Press event = one-cycle pulse in the cycle the debounced level goes 0->1. Release generates no event.
  - Holding a button yields exactly one event.
- Event priority when several events arrive in one cycle: clr > start > lap. Lower-priority events that cycle are dropped.
- FSM: transitions are registered on the cycle after the event pulse. Ignored events cause no change.
  - IDLE:
    - start -> RUN; prescaler cleared to 0.
    - clr -> stay IDLE; cnt_clr pulse.
    - lap ignored.
  - RUN:
    - start -> PAUSE.
    - lap -> LAP; disp_freeze rises with the state change.
    - clr ignored.
  - LAP (counting continues, display frozen):
    - lap -> RUN; disp_freeze falls.
    - start -> PAUSE; disp_freeze falls.
    - clr ignored.
  - PAUSE:
    - start -> RUN; prescaler keeps its value, so the partial tick is preserved.
    - clr -> IDLE; cnt_clr pulse; prescaler cleared.
    - lap ignored.
- Prescaler:
  - Counts only in RUN and LAP; holds in IDLE and PAUSE.
  - When prescaler==TICK_DIV-1 it wraps to 0 and cnt_tick=1 for that cycle.
  - First tick after IDLE->RUN arrives exactly TICK_DIV cycles after state becomes RUN.
- Simultaneous events:
  - A tick coinciding with a start event that causes RUN->PAUSE is still emitted, then counting halts.
  - cnt_clr and cnt_tick are never high in the same cycle, because clr is only accepted in IDLE or PAUSE.
- Output timing:
  - cnt_clr is registered; it is high for the single cycle in which state updates.
  - running and disp_freeze are registered decodes of the next state, so they change in the same cycle as state.
- Widths: prescaler is clog2(TICK_DIV) bits; debounce counters are clog2(DEBOUNCE_CYC+1) bits. No arithmetic overflow is possible within the legal ranges.

Optional Feature:
SW_LAPCNT_EN.
- Defined: adds output lap_cnt [3:0].
  - Reset 0.
  - Increments on each RUN->LAP transition; saturates at 15.
  - Cleared to 0 together with every cnt_clr pulse.
- Undefined: port lap_cnt and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use TICK_DIV=4 and DEBOUNCE_CYC=3.
1. Reset then idle: rst high 2 cycles, then low for 50 cycles -> state=00; cnt_tick, cnt_clr, disp_freeze, running all 0 throughout.
2. Start and tick: btn_start held 10 cycles -> exactly one event; state=01; running=1; cnt_tick pulses every 4th cycle, first pulse 4 cycles after state=01; 5 ticks in 20 cycles.
3. Bounce rejection: btn_start toggled every cycle for 10 cycles, then released -> no event; state stays 00.
4. Pause and resume: RUN, start pressed with prescaler=2 -> PAUSE, no ticks. Press start again -> RUN; first tick 2 cycles after re-entry. Then press clr in PAUSE -> one-cycle cnt_clr pulse, state=00.
5. Lap freeze: in RUN press lap -> state=11, disp_freeze=1, ticks continue. Press lap -> state=01, disp_freeze=0. With SW_LAPCNT_EN defined, lap_cnt=1; after 16 laps lap_cnt=15.
6. Priority and async reset: clr and start debounced in the same cycle while in PAUSE -> IDLE with cnt_clr pulse, no RUN. Assert rst between clock edges while in LAP -> all outputs 0 and state=00 before the next edge.
